// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between fetch (IF) and load/store (LS), LS first.
// Optional IF anti-starvation when ARB_FAIRNESS_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  input  logic [1:0]            ls_type_i,
  input  logic                  ls_sign_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  ls_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ERR} state_t;

  state_t                state_q;
  logic                  owner_ls_q;
  logic                  we_q;
  logic [1:0]            type_q;
  logic                  sign_q;
  logic [1:0]            off_q;
  logic [CW-1:0]         cnt_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  in_idle;
  logic                  force_if;
  logic                  grant;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_off;
  logic                  req_misal;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_data;

  // Grants are combinational so the requester sees acceptance in the request cycle.
  assign in_idle  = rst_ni & (state_q == S_IDLE);
  assign ls_gnt_o = in_idle & ls_req_i & ~force_if;
  assign if_gnt_o = in_idle & if_req_i & (~ls_req_i | force_if);
  assign grant    = ls_gnt_o | if_gnt_o;
  assign req_addr = ls_gnt_o ? ls_addr_i : if_addr_i;
  assign req_off  = req_addr[1:0];

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  assign force_if = if_req_i & (starve_q >= SW'(STARVE_LIMIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (if_gnt_o) begin
      starve_q <= '0;
    end else if (ls_gnt_o && if_req_i && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    req_misal = (req_off != 2'b00);
    if (ls_gnt_o) begin
      case (ls_type_i)
        2'b00:   req_misal = (req_off != 2'b00);
        2'b01:   req_misal = 1'b0;
        2'b10:   req_misal = req_off[0];
        default: req_misal = 1'b1;
      endcase
    end
  end

  // Sub-word stores replicate the value so any lane selected by be carries it.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = ls_wdata_i;
    case (ls_type_i)
      2'b01: begin
        st_be    = 4'b0001 << req_off;
        st_wdata = {4{ls_wdata_i[7:0]}};
      end
      2'b10: begin
        st_be    = 4'b0011 << req_off;
        st_wdata = {2{ls_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_ls_q  <= 1'b0;
      we_q        <= 1'b0;
      type_q      <= 2'b00;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            owner_ls_q <= ls_gnt_o;
            we_q       <= ls_gnt_o & ls_we_i;
            type_q     <= ls_gnt_o ? ls_type_i : 2'b00;
            sign_q     <= ls_sign_i;
            off_q      <= req_off;
            if (req_misal) begin
              state_q <= S_ERR;
            end else begin
              state_q    <= S_ACCESS;
              mem_en_q   <= 1'b1;
              mem_we_q   <= ls_gnt_o & ls_we_i;
              mem_addr_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (ls_gnt_o && ls_we_i) begin
                mem_be_q    <= st_be;
                mem_wdata_q <= st_wdata;
              end else begin
                mem_be_q <= 4'hF;
              end
            end
          end
        end
        S_ACCESS: begin
          mem_en_q <= 1'b0;
          cnt_q    <= CW'(MEM_LATENCY);
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = ((state_q == S_WAIT) && (cnt_q == CW'(1))) || (state_q == S_ERR);
  assign rsp_err   = (state_q == S_ERR);
  assign lane      = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_data = mem_rdata_i;
    case (type_q)
      2'b01:   load_data = sign_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b10:   load_data = sign_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  assign ls_rvalid_o = rsp_valid & owner_ls_q;
  assign if_rvalid_o = rsp_valid & ~owner_ls_q;
  assign ls_err_o    = ls_rvalid_o & rsp_err;
  assign if_err_o    = if_rvalid_o & rsp_err;
  assign ls_rdata_o  = (ls_rvalid_o & ~rsp_err & ~we_q) ? load_data : '0;
  assign if_rdata_o  = (if_rvalid_o & ~rsp_err) ? mem_rdata_i : '0;

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a byte-level memory and arbitration model.
module tb_mem_port_arbiter;
  localparam int L  = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        if_req_i, ls_req_i, ls_we_i, ls_sign_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i, mem_rdata_i;
  logic [1:0]  ls_type_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_en_o, mem_we_o;
  logic [3:0]  mem_be_o;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
    .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_type_i(ls_type_i), .ls_sign_i(ls_sign_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          ls;
    int          cyc;
    bit          err;
    bit          we;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_t;

  rsp_t        rq[$];
  mem_t        mq[$];
  bit [7:0]    mb[2048];
  logic [31:0] rw[512];
  int          free_cyc = 0;
  int          starve = 0;
  int          rd_cyc = -1;
  logic [31:0] rd_word = '0;
  logic [31:0] last_ls_rdata = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_be = '0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] w);
    rw[idx] = w;
    for (int k = 0; k < 4; k++) mb[4*idx+k] = w[8*k +: 8];
  endtask

  // Expected outcome of a granted request, derived from byte-addressed memory semantics.
  function automatic void push_txn(input bit is_ls);
    rsp_t        r;
    mem_t        m;
    int          a;
    logic [1:0]  o;
    bit          mis;
    logic [31:0] v;
    logic [1:0]  t;
    a = is_ls ? int'(ls_addr_i[10:0]) : int'(if_addr_i[10:0]);
    o = a[1:0];
    t = is_ls ? ls_type_i : 2'b00;
    mis = (t == 2'b11) || (t == 2'b00 && o != 2'b00) || (t == 2'b10 && o[0]);
    r.ls = is_ls;
    r.err = mis;
    r.we = is_ls && ls_we_i;
    r.rdata = '0;
    r.cyc = cyc + (mis ? 1 : L + 1);
    free_cyc = cyc + (mis ? 2 : L + 2);
`ifdef ARB_FAIRNESS_EN
    if (!is_ls) starve = 0;
    else if (if_req_i && starve < SL) starve++;
`endif
    if (!mis) begin
      m.cyc = cyc + 1;
      m.addr = 32'(a) & 32'hFFFF_FFFC;
      m.we = r.we;
      m.be = 4'hF;
      m.wdata = '0;
      if (r.we) begin
        case (t)
          2'b01: begin
            m.be = 4'b0001 << o;
            m.wdata = {4{ls_wdata_i[7:0]}};
            mb[a] = ls_wdata_i[7:0];
          end
          2'b10: begin
            m.be = 4'b0011 << o;
            m.wdata = {2{ls_wdata_i[15:0]}};
            mb[a] = ls_wdata_i[7:0];
            mb[a+1] = ls_wdata_i[15:8];
          end
          default: begin
            m.wdata = ls_wdata_i;
            for (int k = 0; k < 4; k++) mb[a+k] = ls_wdata_i[8*k +: 8];
          end
        endcase
      end else begin
        case (t)
          2'b01:   v = ls_sign_i ? {24'h0, mb[a]} : {{24{mb[a][7]}}, mb[a]};
          2'b10:   v = ls_sign_i ? {16'h0, mb[a+1], mb[a]} : {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
          default: v = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
        endcase
        r.rdata = v;
      end
      mq.push_back(m);
    end
    rq.push_back(r);
  endfunction

  // Grant checker and scoreboard producer.
  always @(negedge clk) begin
    bit free, frc, e_ls, e_if;
    if (rst_ni) begin
      free = (cyc >= free_cyc);
      frc = 1'b0;
`ifdef ARB_FAIRNESS_EN
      frc = (starve >= SL);
`endif
      e_ls = free && ls_req_i && !(frc && if_req_i);
      e_if = free && if_req_i && !e_ls;
      checks++;
      if ({ls_gnt_o, if_gnt_o} !== {e_ls, e_if}) begin
        failures++;
        $display("FAIL gnt cyc=%0d got ls=%b if=%b exp ls=%b if=%b", cyc, ls_gnt_o, if_gnt_o, e_ls, e_if);
      end
      if (ls_gnt_o === 1'b1) push_txn(1'b1);
      else if (if_gnt_o === 1'b1) push_txn(1'b0);
    end
  end

  // Response and memory-side monitor.
  always @(negedge clk) begin
    rsp_t        r;
    mem_t        m;
    bit          ok, err_g;
    logic [31:0] rd_g;
    if (rst_ni) begin
      if (ls_rvalid_o || if_rvalid_o) begin
        checks++;
        if (rq.size() == 0 || (ls_rvalid_o && if_rvalid_o)) begin
          failures++;
          $display("FAIL spurious_rvalid cyc=%0d ls=%b if=%b pending=%0d", cyc, ls_rvalid_o, if_rvalid_o, rq.size());
        end else begin
          r = rq.pop_front();
          err_g = ls_rvalid_o ? ls_err_o : if_err_o;
          rd_g = ls_rvalid_o ? ls_rdata_o : if_rdata_o;
          if (ls_rvalid_o) last_ls_rdata = ls_rdata_o;
          ok = (ls_rvalid_o == r.ls) && (cyc == r.cyc) && (err_g == r.err) && (r.err || rd_g == r.rdata);
          $display("txn cyc=%0d port=%s we=%0d err=%0d rdata=%08h", cyc, ls_rvalid_o ? "LS" : "IF", r.we, err_g, rd_g);
          if (!ok) begin
            failures++;
            $display("FAIL rsp got ls=%b cyc=%0d err=%b rdata=%08h exp ls=%b cyc=%0d err=%b rdata=%08h",
                     ls_rvalid_o, cyc, err_g, rd_g, r.ls, r.cyc, r.err, r.rdata);
          end
        end
      end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_rvalid cyc=%0d exp_cyc=%0d", cyc, rq[0].cyc);
        void'(rq.pop_front());
      end
      if (mem_en_o) begin
        checks++;
        if (mq.size() == 0) begin
          failures++;
          $display("FAIL spurious_mem_en cyc=%0d addr=%08h", cyc, mem_addr_o);
        end else begin
          m = mq.pop_front();
          last_be = mem_be_o;
          last_wdata = mem_wdata_o;
          ok = (cyc == m.cyc) && (mem_addr_o == m.addr) && (mem_we_o == m.we) && (mem_be_o == m.be) &&
               (!m.we || mem_wdata_o == m.wdata);
          if (!ok) begin
            failures++;
            $display("FAIL mem got cyc=%0d addr=%08h we=%b be=%h wd=%08h exp cyc=%0d addr=%08h we=%b be=%h wd=%08h",
                     cyc, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, m.cyc, m.addr, m.we, m.be, m.wdata);
          end
        end
      end else if (mq.size() != 0 && mq[0].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_mem_en cyc=%0d exp_cyc=%0d", cyc, mq[0].cyc);
        void'(mq.pop_front());
      end
    end
  end

  // Memory: word-wide with byte enables; read data is valid only in its latency slot.
  always @(negedge clk) begin
    if (rst_ni && mem_en_o) begin
      if (mem_we_o) begin
        for (int k = 0; k < 4; k++)
          if (mem_be_o[k]) rw[mem_addr_o[10:2]][8*k +: 8] = mem_wdata_o[8*k +: 8];
      end else begin
        rd_word = rw[mem_addr_o[10:2]];
        rd_cyc = cyc + L;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rdata_i = (cyc == rd_cyc) ? rd_word : $urandom;
  end

  task automatic ls_do(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] t, input bit s);
    int n;
    @(posedge clk); #1;
    ls_req_i = 1'b1; ls_we_i = we; ls_addr_i = addr; ls_wdata_i = wd; ls_type_i = t; ls_sign_i = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!ls_gnt_o && n < 3000);
    if (!ls_gnt_o) begin
      checks++; failures++;
      $display("FAIL ls_gnt_timeout addr=%08h waited=%0d", addr, n);
    end
    @(posedge clk); #1;
    ls_req_i = 1'b0;
  endtask

  task automatic if_do(input logic [31:0] addr);
    int n;
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt_o && n < 3000);
    if (!if_gnt_o) begin
      checks++; failures++;
      $display("FAIL if_gnt_timeout addr=%08h waited=%0d", addr, n);
    end
    @(posedge clk); #1;
    if_req_i = 1'b0;
  endtask

  task automatic ls_rand();
    logic [31:0] a;
    logic [1:0]  t;
    t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    a = 32'($urandom_range(0, 2047));
    if ($urandom_range(0, 1) == 1) begin
      if (t == 2'b00) a = a & 32'h7FC;
      if (t == 2'b10) a = a & 32'h7FE;
    end
    ls_do(1'($urandom_range(0, 1)), a, $urandom, t, 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rq.size() != 0 || mq.size() != 0 || cyc < free_cyc + 1) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending_rsp=%0d pending_mem=%0d", rq.size(), mq.size());
    end
  endtask

  initial begin
    int n_rv;
    rst_ni = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_type_i = 2'b00; ls_sign_i = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < 512; i++) preload(i, (32'(i) * 32'h0103_0507) ^ 32'h80FF_0000);

    repeat (3) @(posedge clk);
    #1;
    check32("reset_outputs", {26'h0, if_gnt_o, if_rvalid_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_err_o}, 32'h0);
    check32("reset_mem", {28'h0, mem_en_o, mem_we_o, |mem_be_o, |mem_addr_o}, 32'h0);
    rst_ni = 1'b1;

    if_do(32'h100);
    wait_idle();

    preload(32'h200 >> 2, 32'h80FF_FF00);
    ls_do(1'b0, 32'h203, 32'h0, 2'b01, 1'b0);
    wait_idle();
    check32("lb_sext", last_ls_rdata, 32'hFFFF_FF80);
    ls_do(1'b0, 32'h203, 32'h0, 2'b01, 1'b1);
    wait_idle();
    check32("lb_zext", last_ls_rdata, 32'h0000_0080);

    ls_do(1'b1, 32'h402, 32'h1234_ABCD, 2'b10, 1'b0);
    wait_idle();
    check32("sh_be", {28'h0, last_be}, 32'hC);
    check32("sh_wdata", last_wdata, 32'hABCD_ABCD);
    check32("sh_rdata", last_ls_rdata, 32'h0);

    fork
      if_do(32'h104);
      ls_do(1'b0, 32'h300, 32'h0, 2'b00, 1'b0);
    join
    wait_idle();

    ls_do(1'b0, 32'h101, 32'h0, 2'b00, 1'b0);
    wait_idle();

    // Reset while the load sits in its latency wait.
    ls_do(1'b0, 32'h304, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #2;
    rst_ni = 1'b0;
    rq.delete(); mq.delete();
    free_cyc = 0; rd_cyc = -1; starve = 0;
    #1;
    check32("rst_async_outputs", {26'h0, if_gnt_o, if_rvalid_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_err_o}, 32'h0);
    check32("rst_async_mem", {28'h0, mem_en_o, mem_we_o, |mem_be_o, |mem_addr_o}, 32'h0);
    check32("rst_async_rdata", ls_rdata_o | if_rdata_o | mem_wdata_o, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_ni = 1'b1;
    n_rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (ls_rvalid_o || if_rvalid_o) n_rv++;
    end
    check32("no_rvalid_after_reset", 32'(n_rv), 32'h0);

`ifdef ARB_FAIRNESS_EN
    fork
      begin
        for (int i = 0; i < 6; i++) ls_do(1'b0, 32'h10 + 32'(4 * i), 32'h0, 2'b00, 1'b0);
      end
      if_do(32'h108);
    join
    wait_idle();
`endif

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 12)) @(posedge clk);
          ls_rand();
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          if_do(($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 2047)) : 32'($urandom_range(0, 2047)) & 32'h7FC);
        end
      end
    join
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
